bcd_display_controller: RTL and testbench
=========================================

Name: bcd_display_controller

Overview:
- Parametrised seven-segment display front end that converts a binary game value to DIGITS BCD nibbles for the hex decoders.
- Converts iteratively with a sequential double-dabble (shift-and-add-3) engine, so no divide/modulo logic is needed.
- Adds leading-zero blanking, overflow saturation, a blinking low-value warning and lamp-test passthrough.
- Sits between game-state logic (timer/score) and the per-digit hex-to-segment decoders.

Parameters:
- BIN_W, 12, width of binary input value
- DIGITS, 4, number of BCD digits driven (1..8)
- BLINK_HALF, 25000000, clock cycles per blink half-period (on or off)
- WARN_LEVEL, 10, values 1..WARN_LEVEL blink; 0 disables blinking
- LZ_BLANK, 1, 1 = blank leading zero digits; 0 = show all digits

Ports:
- clk  input  1  system clock
- resetN  input  1  asynchronous active-low reset
- value  input  BIN_W  binary value to display
- load  input  1  one-cycle strobe: convert value
- lampTestReq  input  1  lamp-test request
- busy  output  1  conversion in progress
- digitsValid  output  1  one-cycle pulse when hexDigits/digitBlankN update
- hexDigits  output  4*DIGITS  BCD digits; digit i at [4i+3:4i], digit 0 = units
- digitBlankN  output  DIGITS  per-digit enable, 0 = digit blanked
- overflow  output  1  last converted value >= 10^DIGITS
- LampTest  output  1  lamp-test drive to decoders
- darkN  output  1  global display enable, 0 = all dark

Behaviour:
- Reset (async, resetN=0):
  - FSM to IDLE; pending flag cleared; blink counter 0.
  - hexDigits=0, digitBlankN=0, overflow=0, busy=0, digitsValid=0, LampTest=0, darkN=0.
  - Reset mid-conversion aborts it; no digitsValid pulse follows.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: load=1 at edge k captures value into shift register, clears BCD scratch, sets bit counter 0, goes to SHIFT.
  - SHIFT: one double-dabble step per cycle. Each BCD nibble >=5 gets +3, then {bcd,bin} shifts left by 1. After BIN_W steps (edges k+1..k+BIN_W) goes to DONE.
  - DONE: at edge k+BIN_W+1, result registers update and digitsValid=1 for exactly that cycle. Then goes to IDLE, or to SHIFT with the pending value if the pending flag is set.
- busy=1 whenever the state is SHIFT or DONE.
- Latency: load to new digits = BIN_W+1 cycles (13 at default).
- Load while busy: value is stored in a one-deep pending register and the pending flag is set; the last such load wins. Conversion restarts from DONE with no IDLE cycle.
- Load in the DONE cycle is treated as pending.
- BCD scratch width is 4*DIGITS+4 bits, so no truncation during the shift.
- Overflow:
  - Computed at capture: value >= 10^DIGITS, a constant compare.
  - On overflow, hexDigits are forced to all 9s at DONE and overflow=1.
  - overflow clears on the next non-overflow conversion.
- Leading-zero blanking, updated at DONE:
  - LZ_BLANK=1: digitBlankN[i]=1 if i=0 or any digit j>=i is non-zero.
  - LZ_BLANK=0: all ones.
  - Overflow: all ones.
- darkN, registered each cycle from the last converted result:
  - 0 if the result is 0 and there is no overflow (display dark, matches existing timer behaviour).
  - If 1 <= result <= WARN_LEVEL: follows the blink phase.
  - Otherwise 1.
  - Before the first conversion: 0.
- Blink:
  - Free-running counter wraps at BLINK_HALF-1 and toggles the phase.
  - Counter and phase are reset to 0 (lit) on the cycle the result enters the warning range from outside it.
  - Phase lit gives darkN=1; phase off gives darkN=0.
- Lamp test: LampTest = lampTestReq registered (1-cycle delay). While LampTest=1, darkN is forced to 1 and digitBlankN to all ones. Conversion continues unaffected.
- Simultaneous load and lampTestReq are independent; both take effect.

Test Plan:
- Reset, load value=1234 at cycle 5 -> busy cycles 5..17, digitsValid pulse at cycle 18, hexDigits=0x1234, digitBlankN=4'b1111, darkN=1, overflow=0.
- load value=7 -> hexDigits=0x0007, digitBlankN=4'b0001. Repeat with LZ_BLANK=0 -> digitBlankN=4'b1111.
- load value=4095 with DIGITS=3 -> hexDigits=0x999, overflow=1. Then load 42 -> overflow=0, hexDigits=0x042, digitBlankN=3'b011.
- load 100, then load 200 at 5 cycles into busy, then load 300 two cycles later -> two digitsValid pulses, showing 100 then 300. The second conversion starts with no idle gap; 200 is never shown.
- BLINK_HALF=4, load 5 -> darkN toggles every 4 cycles starting lit. Load 0 -> darkN=0 steady. Assert lampTestReq -> LampTest=1 and darkN=1 one cycle later.
- Assert resetN=0 at cycle 6 of a conversion -> all outputs at reset values immediately, no digitsValid pulse, and a fresh load converts normally.

Source files
------------

// File: rtl/bcd_display_controller.sv
// Binary-to-BCD display front end: sequential double-dabble conversion with
// leading-zero blanking, overflow saturation, low-value blink and lamp test.
module bcd_display_controller #(
   parameter int BIN_W      = 12,
   parameter int DIGITS     = 4,
   parameter int BLINK_HALF = 25000000,
   parameter int WARN_LEVEL = 10,
   parameter int LZ_BLANK   = 1
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic [BIN_W-1:0]      value,
   input  logic                  load,
   input  logic                  lampTestReq,
   output logic                  busy,
   output logic                  digitsValid,
   output logic [4*DIGITS-1:0]   hexDigits,
   output logic [DIGITS-1:0]     digitBlankN,
   output logic                  overflow,
   output logic                  LampTest,
   output logic                  darkN
);

   // state   | meaning
   // S_IDLE  | waiting for load
   // S_SHIFT | one shift-and-add-3 step per cycle, BIN_W steps
   // S_DONE  | publish result; restart at once if a load is pending
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   localparam int SW = 4*DIGITS + 4;
   localparam int CW = $clog2(BIN_W + 1);
   localparam int BW = $clog2(BLINK_HALF + 1);

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   localparam logic [63:0] LIMIT    = pow10(DIGITS);
   localparam logic [63:0] WARN_LIM = 64'(WARN_LEVEL);

   state_t                r_state, w_state_n;
   logic [BIN_W-1:0]      r_bin, r_cap_val, r_pend_val, w_cap_val;
   logic [SW-1:0]         r_bcd, w_adj;
   logic [SW+BIN_W-1:0]   w_sh;
   logic [CW-1:0]         r_cnt;
   logic                  r_cap_ovf, r_pend;
   logic [4*DIGITS-1:0]   r_hex;
   logic [DIGITS-1:0]     r_blank, w_lz;
   logic                  r_ovf, r_valid, r_lamp, r_dark;
   logic                  r_res_zero, r_res_warn;
   logic [BW-1:0]         r_blink_cnt, w_blink_cnt_n;
   logic                  r_phase, w_phase_n;
   logic                  w_capture, w_done, w_res_zero_n, w_res_warn_n, w_enter, w_dark_n;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) r_state <= S_IDLE;
      else         r_state <= w_state_n;
   end

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         S_IDLE:  if (load) w_state_n = S_SHIFT;
         S_SHIFT: if (r_cnt == CW'(BIN_W-1)) w_state_n = S_DONE;
         S_DONE:  w_state_n = (load || r_pend) ? S_SHIFT : S_IDLE;
         default: w_state_n = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != S_IDLE);
   end

   assign w_done    = (r_state == S_DONE);
   assign w_capture = ((r_state == S_IDLE) && load) || (w_done && (load || r_pend));
   // A load arriving in the DONE cycle is newer than anything pending.
   assign w_cap_val = load ? value : r_pend_val;

   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i <= DIGITS; i++)
         if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
   end

   assign w_sh = {w_adj, r_bin} << 1;

   always_comb begin
      logic v_acc;
      v_acc = 1'b0;
      w_lz  = '0;
      for (int i = DIGITS-1; i >= 0; i--) begin
         v_acc   = v_acc | (r_bcd[4*i +: 4] != 4'd0);
         w_lz[i] = v_acc | (i == 0);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_bin      <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_cap_val  <= '0;
         r_cap_ovf  <= 1'b0;
         r_pend     <= 1'b0;
         r_pend_val <= '0;
      end else begin
         if (w_capture) begin
            r_bin     <= w_cap_val;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_cap_val <= w_cap_val;
            r_cap_ovf <= (64'(w_cap_val) >= LIMIT);
         end else if (r_state == S_SHIFT) begin
            r_bcd <= w_sh[SW+BIN_W-1:BIN_W];
            r_bin <= w_sh[BIN_W-1:0];
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_done) begin
            r_pend <= 1'b0;
         end else if (load && (r_state == S_SHIFT)) begin
            r_pend     <= 1'b1;
            r_pend_val <= value;
         end
      end
   end

   assign w_res_zero_n = w_done ? (r_cap_val == '0) : r_res_zero;
   assign w_res_warn_n = w_done ? (!r_cap_ovf && (r_cap_val != '0) && (64'(r_cap_val) <= WARN_LIM))
                                : r_res_warn;
   assign w_enter      = w_done && w_res_warn_n && !r_res_warn;

   always_comb begin
      w_blink_cnt_n = r_blink_cnt + BW'(1);
      w_phase_n     = r_phase;
      if (w_enter) begin
         w_blink_cnt_n = '0;
         w_phase_n     = 1'b0;
      end else if (r_blink_cnt == BW'(BLINK_HALF-1)) begin
         w_blink_cnt_n = '0;
         w_phase_n     = ~r_phase;
      end
   end

   // darkN is computed from next-cycle result state so it lands with digitsValid.
   assign w_dark_n = lampTestReq || (!w_res_zero_n && (!w_res_warn_n || !w_phase_n));

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_hex       <= '0;
         r_blank     <= '0;
         r_ovf       <= 1'b0;
         r_valid     <= 1'b0;
         r_lamp      <= 1'b0;
         r_dark      <= 1'b0;
         r_res_zero  <= 1'b1;
         r_res_warn  <= 1'b0;
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
      end else begin
         r_valid     <= w_done;
         r_lamp      <= lampTestReq;
         r_dark      <= w_dark_n;
         r_res_zero  <= w_res_zero_n;
         r_res_warn  <= w_res_warn_n;
         r_blink_cnt <= w_blink_cnt_n;
         r_phase     <= w_phase_n;
         if (w_done) begin
            r_hex   <= r_cap_ovf ? {DIGITS{4'h9}} : r_bcd[4*DIGITS-1:0];
            r_blank <= (r_cap_ovf || (LZ_BLANK == 0)) ? '1 : w_lz;
            r_ovf   <= r_cap_ovf;
         end
      end
   end

   assign digitsValid = r_valid;
   assign hexDigits   = r_hex;
   assign digitBlankN = r_blank | {DIGITS{r_lamp}};
   assign overflow    = r_ovf;
   assign LampTest    = r_lamp;
   assign darkN       = r_dark;

endmodule

// File: tb/tb_bcd_display_controller.sv
// Directed bench for bcd_display_controller: three configurations share stimulus,
// converted results are checked against a decimal model through per-instance queues.
module tb_bcd_display_controller;

   logic        clk = 1'b0;
   logic        resetN;
   logic [11:0] value;
   logic        load;
   logic        lampTestReq;

   logic        a_busy, a_dv, a_ovf, a_lt, a_dark;
   logic [15:0] a_hex;
   logic [3:0]  a_blank;
   logic        b_busy, b_dv, b_ovf, b_lt, b_dark;
   logic [15:0] b_hex;
   logic [3:0]  b_blank;
   logic        c_busy, c_dv, c_ovf, c_lt, c_dark;
   logic [11:0] c_hex;
   logic [2:0]  c_blank;

   int n_assert = 0;
   int n_fail   = 0;
   logic [20:0] q_a[$];
   logic [20:0] q_b[$];
   logic [20:0] q_c[$];

   always #5 clk = ~clk;

   bcd_display_controller #(.BIN_W(12), .DIGITS(4), .BLINK_HALF(4), .WARN_LEVEL(10), .LZ_BLANK(1)) u_a (
      .clk(clk), .resetN(resetN), .value(value), .load(load), .lampTestReq(lampTestReq),
      .busy(a_busy), .digitsValid(a_dv), .hexDigits(a_hex), .digitBlankN(a_blank),
      .overflow(a_ovf), .LampTest(a_lt), .darkN(a_dark));

   bcd_display_controller #(.BIN_W(12), .DIGITS(4), .BLINK_HALF(4), .WARN_LEVEL(10), .LZ_BLANK(0)) u_b (
      .clk(clk), .resetN(resetN), .value(value), .load(load), .lampTestReq(lampTestReq),
      .busy(b_busy), .digitsValid(b_dv), .hexDigits(b_hex), .digitBlankN(b_blank),
      .overflow(b_ovf), .LampTest(b_lt), .darkN(b_dark));

   bcd_display_controller #(.BIN_W(12), .DIGITS(3), .BLINK_HALF(4), .WARN_LEVEL(10), .LZ_BLANK(1)) u_c (
      .clk(clk), .resetN(resetN), .value(value), .load(load), .lampTestReq(lampTestReq),
      .busy(c_busy), .digitsValid(c_dv), .hexDigits(c_hex), .digitBlankN(c_blank),
      .overflow(c_ovf), .LampTest(c_lt), .darkN(c_dark));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Decimal model: {overflow, blankN[3:0], hex[15:0]}
   function automatic logic [20:0] model(input int v, input int nd, input bit lz);
      logic [15:0] h;
      logic [3:0]  b;
      int p, lim;
      h = '0; b = '0; p = 1; lim = 1;
      for (int i = 0; i < nd; i++) lim = lim * 10;
      if (v >= lim) begin
         for (int i = 0; i < nd; i++) begin
            h[4*i +: 4] = 4'h9;
            b[i] = 1'b1;
         end
         return {1'b1, b, h};
      end
      for (int i = 0; i < nd; i++) begin
         h[4*i +: 4] = 4'((v / p) % 10);
         b[i] = !lz || (i == 0) || (v >= p);
         p = p * 10;
      end
      return {1'b0, b, h};
   endfunction

   task automatic pulse_load(input int v, input bit push);
      value = 12'(v);
      load  = 1'b1;
      @(posedge clk); #1;
      load  = 1'b0;
      if (push) begin
         q_a.push_back(model(v, 4, 1'b1));
         q_b.push_back(model(v, 4, 1'b0));
         q_c.push_back(model(v, 3, 1'b1));
      end
   endtask

   task automatic wait_dv(output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!a_dv && n < 60);
      check("dv_seen", 64'(a_dv), 64'd1);
   endtask

   always @(negedge clk) begin
      if (resetN) begin
         if (a_dv) begin
            if (q_a.size() != 0) check("a_result", 64'({a_ovf, a_blank, a_hex}), 64'(q_a.pop_front()));
            else                 check("a_unexpected_valid", 64'(a_dv), 64'd0);
         end
         if (b_dv) begin
            if (q_b.size() != 0) check("b_result", 64'({b_ovf, b_blank, b_hex}), 64'(q_b.pop_front()));
            else                 check("b_unexpected_valid", 64'(b_dv), 64'd0);
         end
         if (c_dv) begin
            if (q_c.size() != 0) check("c_result", 64'({c_ovf, 1'b0, c_blank, 4'h0, c_hex}), 64'(q_c.pop_front()));
            else                 check("c_unexpected_valid", 64'(c_dv), 64'd0);
         end
      end
   end

   initial begin
      int n;
      resetN = 1'b0; load = 1'b0; value = '0; lampTestReq = 1'b0;
      repeat (2) @(posedge clk); #1;
      check("rst_outputs", 64'({a_hex, a_blank, a_ovf, a_busy, a_dv, a_lt, a_dark}), 64'd0);
      resetN = 1'b1;
      @(posedge clk); #1;

      // 1234: latency and busy window
      pulse_load(1234, 1'b1);
      check("busy_after_load", 64'(a_busy), 64'd1);
      wait_dv(n);
      check("latency_1234", 64'(n), 64'd13);
      check("busy_at_valid", 64'(a_busy), 64'd0);
      check("dark_1234", 64'(a_dark), 64'd1);
      @(posedge clk); #1;
      check("valid_one_cycle", 64'(a_dv), 64'd0);

      // small value, leading zeros
      pulse_load(7, 1'b1);
      wait_dv(n);
      check("blank_7", 64'(a_blank), 64'b0001);
      check("blank_7_nolz", 64'(b_blank), 64'b1111);

      // overflow on the 3-digit instance, then recovery
      pulse_load(4095, 1'b1);
      wait_dv(n);
      check("ovf_4095", 64'({c_ovf, c_hex}), 64'h1999);
      pulse_load(42, 1'b1);
      wait_dv(n);
      check("ovf_clear_42", 64'({c_ovf, c_blank, c_hex}), 64'h3042);

      // pending loads: 200 is superseded by 300
      pulse_load(100, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      pulse_load(200, 1'b0);
      @(posedge clk); #1;
      pulse_load(300, 1'b1);
      wait_dv(n);
      check("pend_first_at", 64'(n), 64'd6);
      check("pend_busy_kept", 64'(a_busy), 64'd1);
      wait_dv(n);
      check("pend_second_at", 64'(n), 64'd13);
      check("pend_hex_300", 64'(a_hex), 64'h0300);

      // blink at BLINK_HALF=4
      pulse_load(5, 1'b1);
      wait_dv(n);
      for (int j = 0; j < 16; j++) begin
         check($sformatf("blink_%0d", j), 64'(a_dark), 64'(((j / 4) % 2) == 0));
         @(posedge clk); #1;
      end

      // zero goes dark, lamp test overrides
      pulse_load(0, 1'b1);
      wait_dv(n);
      for (int j = 0; j < 3; j++) begin
         check("dark_zero", 64'(a_dark), 64'd0);
         @(posedge clk); #1;
      end
      lampTestReq = 1'b1;
      check("lamp_delay", 64'(a_lt), 64'd0);
      @(posedge clk); #1;
      check("lamp_on", 64'({a_lt, a_dark, a_blank}), 64'b111111);
      lampTestReq = 1'b0;
      @(posedge clk); #1;
      check("lamp_off", 64'({a_lt, a_dark, a_blank}), 64'b000001);

      // reset in the middle of a conversion
      pulse_load(1234, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      resetN = 1'b0;
      #1;
      check("rst_mid_outputs", 64'({a_hex, a_blank, a_ovf, a_busy, a_dv, a_lt, a_dark}), 64'd0);
      q_a.delete(); q_b.delete(); q_c.delete();
      repeat (20) @(posedge clk);
      check("rst_no_valid", 64'({a_dv, b_dv, c_dv}), 64'd0);
      #1;
      resetN = 1'b1;
      @(posedge clk); #1;
      pulse_load(56, 1'b1);
      wait_dv(n);
      check("latency_after_rst", 64'(n), 64'd13);
      check("dark_56", 64'(a_dark), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      check("queues_drained", 64'(q_a.size() + q_b.size() + q_c.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
